// File: rtl/mmio_pkg.sv
// mmio_pkg: definitions shared by the MMIO bridge and its wait timer.
//   - state_e       : bridge FSM states
//   - TIMER_BASE_HI : upper address half that selects the timer peripheral
//   - CONFIG_OFF / LOAD_OFF : timer register offsets (lower address half)
//   - resp_t        : response payload {rdata, err}
//   - addr_hit()    : peripheral window decode
package mmio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [15:0] TIMER_BASE_HI = 16'h3FF5;
  localparam logic [15:0] CONFIG_OFF    = 16'hF000;
  localparam logic [15:0] LOAD_OFF      = 16'hF020;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [15:0] base_hi);
    return addr[31:16] == base_hi;
  endfunction

endpackage

// File: rtl/mmio_wait_timer.sv
// mmio_wait_timer: clearable 16-bit cycle counter used to bound the read
// data wait of the MMIO bridge.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   clr_in  in  synchronous clear to 0 (wins over en_in)
//   en_in   in  increment by one this cycle
//   expired out counter has reached LIMIT-1
module mmio_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_in,
  input  logic en_in,
  output logic expired_out
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = 16'd0;
    end else if (en_in) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_out = (cnt_q == LAST);

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: single-outstanding bridge from a valid/ready request channel
// to the timer peripheral strobe interface.
//
// Handshake rule (both channels): a transfer happens in a cycle where valid
// and ready are both 1 at the rising edge; a producer holds valid and its
// payload stable until that cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_*               request channel in (addr, wdata, we), req_ready_out
//   resp_*              response channel out (rdata, err), resp_ready_in
//   addr_out/data_out   address/data to peripheral, held between accepts
//   wr_out/rd_out       one-cycle write/read strobes
//   rd_valid_in/data_in read return from peripheral (only honoured in WAIT)
//   state_dbg_out       current FSM state (mmio_pkg::state_e encoding)
//
// Build option: define MMIO_BRIDGE_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles (timeout returns err=1). Without it WAIT only exits
// on rd_valid_in and no counter exists.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_HI        = TIMER_BASE_HI,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic        req_we_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic [31:0] addr_out,
  output logic [31:0] data_out,
  output logic        wr_out,
  output logic        rd_out,
  input  logic        rd_valid_in,
  input  logic [31:0] data_in,
  output logic [2:0]  state_dbg_out
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mmio_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  resp_t       resp_q, resp_d;

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  logic tmr_clr, tmr_en, tmr_expired;

  mmio_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_in      (tmr_clr),
    .en_in       (tmr_en),
    .expired_out (tmr_expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    resp_d  = resp_q;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          // Address/data are latched even on a miss so the peripheral bus
          // always reflects the last accepted request.
          addr_d = req_addr_in;
          data_d = req_wdata_in;
          if (!addr_hit(req_addr_in, BASE_HI)) begin
            resp_d  = '{rdata: 32'h0, err: 1'b1};
            state_d = ST_RESP;
          end else if (req_we_in) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        resp_d  = '{rdata: 32'h0, err: 1'b0};
        state_d = ST_RESP;
      end
      ST_READ: begin
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        tmr_clr = 1'b1;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Read data beats a simultaneous timeout.
        if (rd_valid_in) begin
          resp_d  = '{rdata: data_in, err: 1'b0};
          state_d = ST_RESP;
        end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        else if (tmr_expired) begin
          resp_d  = '{rdata: 32'h0, err: 1'b1};
          state_d = ST_RESP;
        end else begin
          tmr_en = 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  // Strobes decode registered state, so they are clean one-cycle pulses
  // and drop to 0 the moment reset is asserted.
  assign req_ready_out  = (state_q == ST_IDLE);
  assign wr_out         = (state_q == ST_WRITE);
  assign rd_out         = (state_q == ST_READ);
  assign resp_valid_out = (state_q == ST_RESP);
  assign resp_rdata_out = resp_q.rdata;
  assign resp_err_out   = resp_q.err;
  assign addr_out       = addr_q;
  assign data_out       = data_q;
  assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: table-driven self-checking bench for mmio_bridge with a
// response scoreboard. Works with or without MMIO_BRIDGE_TIMEOUT_EN.
module tb_mmio_bridge;
  import mmio_pkg::*;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        req_we_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic        wr_out;
  logic        rd_out;
  logic        rd_valid_in;
  logic [31:0] data_in;
  logic [2:0]  state_dbg_out;

  mmio_bridge #(
    .BASE_HI        (16'h3FF5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_addr_in    (req_addr_in),
    .req_wdata_in   (req_wdata_in),
    .req_we_in      (req_we_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .resp_rdata_out (resp_rdata_out),
    .resp_err_out   (resp_err_out),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .wr_out         (wr_out),
    .rd_out         (rd_out),
    .rd_valid_in    (rd_valid_in),
    .data_in        (data_in),
    .state_dbg_out  (state_dbg_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {err, rdata}
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic pop_chk(input string name);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: response with empty expected queue (t=%0t)", name, $time);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_rdata"}, resp_rdata_out, e[31:0]);
      chk({name, "_err"}, {31'h0, resp_err_out}, {31'h0, e[32]});
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs sampled #4 later, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          rv_delay;   // cycles after rd_out cycle; <=0 = none
    logic [31:0] rv_data;
    int          exp_lat;    // cycles from accept to first resp_valid
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_wr;
    logic        exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic do_txn(input int idx, input vec_t v);
    int k;
    bit done;
    int wr_cnt, rd_cnt, wr_k, rd_k;
    string nm;
    nm = $sformatf("v%0d", idx);
    wr_cnt = 0; rd_cnt = 0; wr_k = 0; rd_k = 0; done = 0; k = 0;
    req_valid_in = 1'b1;
    req_addr_in  = v.addr;
    req_wdata_in = v.wdata;
    req_we_in    = v.we;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    #4;
    chk({nm, "_req_ready"}, {31'h0, req_ready_out}, 32'h1);
    tick();
    req_valid_in = 1'b0;
    while (!done && k < 150) begin
      k++;
      rd_valid_in   = 1'b0;
      data_in       = $urandom;
      resp_ready_in = 1'b1;
      // Stray return in the cycle after accept must always be ignored.
      if (k == 1) begin
        rd_valid_in = 1'b1;
        data_in     = 32'hDEAD_BEEF;
      end
      if (v.rv_delay > 0 && k == 1 + v.rv_delay) begin
        rd_valid_in = 1'b1;
        data_in     = v.rv_data;
      end
      #4;
      if (wr_out) begin
        wr_cnt++;
        if (wr_cnt == 1) wr_k = k;
        chk({nm, "_wr_addr"}, addr_out, v.addr);
        chk({nm, "_wr_data"}, data_out, v.wdata);
      end
      if (rd_out) begin
        rd_cnt++;
        if (rd_cnt == 1) rd_k = k;
        chk({nm, "_rd_addr"}, addr_out, v.addr);
      end
      if (resp_valid_out) begin
        chk({nm, "_latency"}, k, v.exp_lat);
        pop_chk(nm);
        done = 1;
      end
      tick();
    end
    rd_valid_in = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL %s_no_resp: got none expected response within 150 cycles", nm);
      void'(exp_q.pop_front());
    end
    chk({nm, "_wr_pulses"}, wr_cnt, {31'h0, v.exp_wr});
    chk({nm, "_rd_pulses"}, rd_cnt, {31'h0, v.exp_rd});
    if (v.exp_wr) chk({nm, "_wr_cycle"}, wr_k, 1);
    if (v.exp_rd) chk({nm, "_rd_cycle"}, rd_k, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req_ready"},  {31'h0, req_ready_out},  32'h1);
    chk({name, "_resp_valid"}, {31'h0, resp_valid_out}, 32'h0);
    chk({name, "_resp_err"},   {31'h0, resp_err_out},   32'h0);
    chk({name, "_wr"},         {31'h0, wr_out},         32'h0);
    chk({name, "_rd"},         {31'h0, rd_out},         32'h0);
    chk({name, "_rdata"},      resp_rdata_out,          32'h0);
    chk({name, "_addr"},       addr_out,                32'h0);
    chk({name, "_data"},       data_out,                32'h0);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [31:0] r4, r6, hold_rdata;
    int k;
    int resp_seen;
    r4 = $urandom;
    r6 = $urandom;

    vecs[0] = '{{TIMER_BASE_HI, CONFIG_OFF}, 32'h8000_0000, 1'b1, 0, 32'h0,
                2, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{{TIMER_BASE_HI, CONFIG_OFF}, 32'h0, 1'b0, 1, 32'h1234_5678,
                3, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'h4000_0000, 32'h0, 1'b0, 0, 32'h0,
                1, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{{TIMER_BASE_HI, LOAD_OFF}, $urandom, 1'b1, 0, 32'h0,
                2, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{{TIMER_BASE_HI, LOAD_OFF}, 32'h0, 1'b0, 3, r4,
                5, r4, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h3FF4_0000, 32'h5555_AAAA, 1'b1, 0, 32'h0,
                1, 32'h0, 1'b1, 1'b0, 1'b0};
    // Return lands on the last WAIT cycle: data must win over timeout.
    vecs[6] = '{{TIMER_BASE_HI, CONFIG_OFF}, 32'h0, 1'b0, TO, r6,
                TO + 2, r6, 1'b0, 1'b0, 1'b1};

    rst = 1'b0;
    req_valid_in = 1'b0; req_addr_in = 32'h0; req_wdata_in = 32'h0; req_we_in = 1'b0;
    resp_ready_in = 1'b0; rd_valid_in = 1'b0; data_in = 32'h0;
    repeat (3) tick();
    #4;
    chk_reset_outputs("reset");
    tick();
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_txn(i, vecs[i]);
    end

    // ---- response back-pressure with a pending request ----
    req_valid_in = 1'b1; req_addr_in = {TIMER_BASE_HI, CONFIG_OFF};
    req_wdata_in = 32'h0; req_we_in = 1'b0;
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    tick();                               // N+1 READ
    req_valid_in = 1'b0; resp_ready_in = 1'b0;
    #4; chk("stall_rd_pulse", {31'h0, rd_out}, 32'h1);
    tick();                               // N+2 WAIT
    rd_valid_in = 1'b1; data_in = 32'hCAFE_F00D;
    tick();                               // N+3.. stall
    rd_valid_in = 1'b0; data_in = 32'h0;
    req_valid_in = 1'b1; req_addr_in = {TIMER_BASE_HI, LOAD_OFF};
    req_wdata_in = 32'h0000_0005; req_we_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        rd_valid_in = 1'b1; data_in = 32'h1111_2222;
      end else begin
        rd_valid_in = 1'b0;
      end
      #4;
      chk("stall_valid", {31'h0, resp_valid_out}, 32'h1);
      chk("stall_rdata", resp_rdata_out, 32'hCAFE_F00D);
      chk("stall_req_ready", {31'h0, req_ready_out}, 32'h0);
      tick();
    end
    rd_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    #4;
    chk("stall_hs_valid", {31'h0, resp_valid_out}, 32'h1);
    pop_chk("stall");
    tick();                               // M+1: pending request accepted
    exp_q.push_back({1'b0, 32'h0});
    #4;
    chk("b2b_req_ready", {31'h0, req_ready_out}, 32'h1);
    tick();                               // M+2 WRITE
    req_valid_in = 1'b0;
    #4;
    chk("b2b_wr", {31'h0, wr_out}, 32'h1);
    chk("b2b_wr_data", data_out, 32'h0000_0005);
    tick();                               // M+3 RESP
    #4;
    chk("b2b_resp_valid", {31'h0, resp_valid_out}, 32'h1);
    pop_chk("b2b");
    tick();

    // ---- timeout / no-timeout behaviour ----
    req_valid_in = 1'b1; req_addr_in = {TIMER_BASE_HI, CONFIG_OFF}; req_we_in = 1'b0;
    tick();
    req_valid_in = 1'b0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    resp_ready_in = 1'b0;
    k = 1;
    resp_seen = 0;
    while (k <= TO + 4) begin
      rd_valid_in = (k == TO + 4);        // late return at N+20
      data_in     = 32'h0BAD_0BAD;
      resp_ready_in = (k == TO + 5 - 1) ? 1'b1 : 1'b0;
      #4;
      if (resp_valid_out && resp_seen == 0) begin
        resp_seen = k;
        chk("to_latency", k, TO + 2);
      end
      if (resp_valid_out) chk("to_rdata_hold", resp_rdata_out, 32'h0);
      if (k == TO + 4) pop_chk("timeout");
      tick();
      k++;
    end
    rd_valid_in = 1'b0; resp_ready_in = 1'b1;
    if (resp_seen == 0) begin
      n_total++;
      $display("FAIL to_no_resp: got none expected response at cycle %0d", TO + 2);
    end
    #4; chk("to_after_valid", {31'h0, resp_valid_out}, 32'h0);
    tick();
`else
    resp_ready_in = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 100; i++) begin
      #4;
      if (resp_valid_out) resp_seen++;
      tick();
    end
    chk("nto_no_resp", resp_seen, 0);
    rd_valid_in = 1'b1; data_in = 32'h0BAD_F00D;
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    tick();
    rd_valid_in = 1'b0;
    #4;
    chk("nto_resp_valid", {31'h0, resp_valid_out}, 32'h1);
    pop_chk("nto");
    tick();
`endif

    // ---- reset in the second WAIT cycle ----
    req_valid_in = 1'b1; req_addr_in = {TIMER_BASE_HI, LOAD_OFF}; req_we_in = 1'b0;
    tick();                               // N+1 READ
    req_valid_in = 1'b0;
    tick();                               // N+2 WAIT 1
    tick();                               // N+3 WAIT 2
    rst = 1'b0;
    #4;
    chk_reset_outputs("midrst");
    tick();
    rst = 1'b1;
    rd_valid_in = 1'b1; data_in = 32'h7777_7777;
    tick();
    rd_valid_in = 1'b0;
    resp_seen = 0;
    hold_rdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      #4;
      if (resp_valid_out) resp_seen++;
      hold_rdata = hold_rdata | resp_rdata_out;
      tick();
    end
    chk("midrst_no_resp", resp_seen, 0);
    chk("midrst_rdata", hold_rdata, 32'h0);
    chk("midrst_ready", {31'h0, req_ready_out}, 32'h1);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
